// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, reset values and write masks.
// CP0_TIMER_EN (when defined) makes Count/Compare writable; otherwise they read as 0.
package cp0_regfile_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  localparam logic [31:0] CAUSE_RESET  = 32'h0000_0000;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

`ifdef CP0_TIMER_EN
  localparam logic [31:0] TIMER_WMASK = 32'hffff_ffff;
`else
  localparam logic [31:0] TIMER_WMASK = 32'h0000_0000;
`endif

  localparam int unsigned STATUS_IE  = 32'd0;
  localparam int unsigned STATUS_EXL = 32'd1;
  localparam int unsigned CAUSE_BD   = 32'd31;

  typedef struct packed {
    logic       hit;
    logic [4:0] code;
  } exc_map_t;

  // Codes outside the table still enter exception state but leave ExcCode untouched.
  function automatic exc_map_t exc_code_map(input logic [31:0] excepttype);
    exc_map_t m;
    case (excepttype)
      EXC_INT:  m = {1'b1, 5'h00};
      EXC_ADEL: m = {1'b1, 5'h04};
      EXC_ADES: m = {1'b1, 5'h05};
      EXC_SYS:  m = {1'b1, 5'h08};
      EXC_BP:   m = {1'b1, 5'h09};
      EXC_RI:   m = {1'b1, 5'h0a};
      EXC_OV:   m = {1'b1, 5'h0c};
      default:  m = {1'b0, 5'h00};
    endcase
    return m;
  endfunction

  function automatic logic [31:0] masked_merge(input logic [31:0] cur, input logic [31:0] wdata,
                                               input logic [31:0] mask);
    return (cur & ~mask) | (wdata & mask);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with sticky match flag. Built only when CP0_TIMER_EN is defined;
// otherwise Count, Compare and the interrupt flag are tied to zero.
module cp0_timer
  import cp0_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

`ifdef CP0_TIMER_EN
  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic        toggle_r;
  logic        timer_int_r;

  // Count advances on edges where toggle is low; a Compare write beats a same-cycle match
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r     <= 32'd0;
      compare_r   <= 32'd0;
      toggle_r    <= 1'b0;
      timer_int_r <= 1'b0;
    end else begin
      if (count_we) begin
        count_r  <= wdata;
        toggle_r <= 1'b0;
      end else begin
        toggle_r <= ~toggle_r;
        count_r  <= toggle_r ? count_r : count_r + 32'd1;
      end
      if (compare_we) begin
        compare_r   <= wdata;
        timer_int_r <= 1'b0;
      end else if ((count_r == compare_r) && (compare_r != 32'd0)) begin
        timer_int_r <= 1'b1;
      end else begin
        timer_int_r <= timer_int_r;
      end
    end
  end

  assign count     = count_r;
  assign compare   = compare_r;
  assign timer_int = timer_int_r;
`else
  logic unused_timer_s;
  assign unused_timer_s = ^{clk, rst, count_we, compare_we, wdata, TIMER_WMASK};
  assign count     = 32'd0;
  assign compare   = 32'd0;
  assign timer_int = 1'b0;
`endif

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: MTC0/MFC0 access, exception/ERET state capture and interrupt request.
// The Count/Compare timer is optional via CP0_TIMER_EN (see cp0_timer).
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int INT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [4:0]       waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [4:0]       raddr_i,
  output logic [31:0]      rdata_o,
  input  logic [INT_W-1:0] int_i,
  input  logic [31:0]      excepttype_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             in_delayslot_i,
  input  logic [PC_W-1:0]  bad_addr_i,
  output logic [31:0]      status_o,
  output logic [31:0]      cause_o,
  output logic [31:0]      epc_o,
  output logic             int_pending_o,
  output logic             timer_int_o
);

  logic [31:0] status_r;
  logic [31:0] cause_r;
  logic [31:0] epc_r;
  logic [31:0] badvaddr_r;
  logic [31:0] count_s;
  logic [31:0] compare_s;
  logic [31:0] rdata_s;
  logic [31:0] pc_s;
  logic [31:0] epc_next_s;
  logic        timer_int_s;
  logic        exc_s;
  logic        eret_s;
  logic        mtc0_s;
  logic        bypass_s;
  logic        exl_s;
  exc_map_t    exc_map_s;

  // Any committed exception or ERET drops a same-cycle MTC0.
  assign exc_s      = (excepttype_i != EXC_NONE) && (excepttype_i != EXC_ERET);
  assign eret_s     = (excepttype_i == EXC_ERET);
  assign mtc0_s     = we_i && (excepttype_i == EXC_NONE);
  assign bypass_s   = mtc0_s && (waddr_i == raddr_i);
  assign exl_s      = status_r[STATUS_EXL];
  assign pc_s       = 32'(pc_i);
  assign epc_next_s = in_delayslot_i ? pc_s - 32'd4 : pc_s;
  assign exc_map_s  = exc_code_map(excepttype_i);

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (mtc0_s && (waddr_i == CP0_COUNT)),
    .compare_we (mtc0_s && (waddr_i == CP0_COMPARE)),
    .wdata      (wdata_i),
    .count      (count_s),
    .compare    (compare_s),
    .timer_int  (timer_int_s)
  );

  // Status: EXL set by exceptions, cleared by ERET, masked MTC0 otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      status_r <= STATUS_RESET;
    end else if (exc_s) begin
      status_r[STATUS_EXL] <= 1'b1;
    end else if (eret_s) begin
      status_r[STATUS_EXL] <= 1'b0;
    end else if (mtc0_s && (waddr_i == CP0_STATUS)) begin
      status_r <= masked_merge(status_r, wdata_i, STATUS_WMASK);
    end else begin
      status_r <= status_r;
    end
  end

  // Cause: hardware IP sampled every cycle, BD/ExcCode on exception, software IP on MTC0
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_r <= CAUSE_RESET;
    end else begin
      cause_r[15:10] <= {int_i[5] | timer_int_s, int_i[4:0]};
      if (exc_s) begin
        cause_r[CAUSE_BD] <= exl_s ? cause_r[CAUSE_BD] : in_delayslot_i;
        cause_r[6:2]      <= exc_map_s.hit ? exc_map_s.code : cause_r[6:2];
      end else if (mtc0_s && (waddr_i == CP0_CAUSE)) begin
        cause_r[9:8] <= wdata_i[9:8];
      end else begin
        cause_r[9:8] <= cause_r[9:8];
      end
    end
  end

  // EPC captures the restart PC only on the first exception (EXL still clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_r <= 32'd0;
    end else if (exc_s) begin
      epc_r <= exl_s ? epc_r : epc_next_s;
    end else if (mtc0_s && (waddr_i == CP0_EPC)) begin
      epc_r <= wdata_i;
    end else begin
      epc_r <= epc_r;
    end
  end

  // BadVAddr is written only by address-error exceptions
  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_r <= 32'd0;
    end else if (excepttype_i == EXC_ADEL || excepttype_i == EXC_ADES) begin
      badvaddr_r <= 32'(bad_addr_i);
    end else begin
      badvaddr_r <= badvaddr_r;
    end
  end

  // MFC0 read mux with same-cycle MTC0 bypass through each register's write mask
  always_comb begin
    rdata_s = 32'd0;
    case (raddr_i)
      CP0_BADVADDR: rdata_s = badvaddr_r;
      CP0_COUNT:    rdata_s = bypass_s ? masked_merge(count_s, wdata_i, TIMER_WMASK) : count_s;
      CP0_COMPARE:  rdata_s = bypass_s ? masked_merge(compare_s, wdata_i, TIMER_WMASK) : compare_s;
      CP0_STATUS:   rdata_s = bypass_s ? masked_merge(status_r, wdata_i, STATUS_WMASK) : status_r;
      CP0_CAUSE:    rdata_s = bypass_s ? masked_merge(cause_r, wdata_i, CAUSE_WMASK) : cause_r;
      CP0_EPC:      rdata_s = bypass_s ? wdata_i : epc_r;
      default:      rdata_s = 32'd0;
    endcase
  end

  assign rdata_o       = rdata_s;
  assign status_o      = status_r;
  assign cause_o       = cause_r;
  assign epc_o         = epc_r;
  assign timer_int_o   = timer_int_s;
  assign int_pending_o = status_r[STATUS_IE] & ~status_r[STATUS_EXL]
                         & (|(cause_r[15:8] & status_r[15:8]));

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios plus randomized traffic against
// a behavioural model (timer tracked as reload value plus elapsed cycles).
`timescale 1ns/1ps
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        int_pending_o;
  logic        timer_int_o;

`ifdef CP0_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] last_rdata;

  logic [31:0] m_status, m_cause, m_epc, m_badv, m_compare, m_base, m_cyc;
  logic        m_timer;
  logic [31:0] codes [8] = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'he};

  cp0_regfile dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .int_i(int_i), .excepttype_i(excepttype_i),
    .pc_i(pc_i), .in_delayslot_i(in_delayslot_i), .bad_addr_i(bad_addr_i),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .int_pending_o(int_pending_o), .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_count();
    return TIMER_ON ? m_base + ((m_cyc + 32'd1) >> 1) : 32'd0;
  endfunction

  function automatic logic [31:0] m_read();
    logic [31:0] r;
    r = 32'd0;
    if (we_i && waddr_i == raddr_i && excepttype_i == 32'd0) begin
      case (raddr_i)
        5'd8:        r = m_badv;
        5'd9, 5'd11: r = TIMER_ON ? wdata_i : 32'd0;
        5'd12:       r = 32'h0040_0000 | (wdata_i & 32'h0000_ff03);
        5'd13:       r = (m_cause & ~32'h0000_0300) | (wdata_i & 32'h0000_0300);
        5'd14:       r = wdata_i;
        default:     r = 32'd0;
      endcase
    end else begin
      case (raddr_i)
        5'd8:    r = m_badv;
        5'd9:    r = m_count();
        5'd11:   r = TIMER_ON ? m_compare : 32'd0;
        5'd12:   r = m_status;
        5'd13:   r = m_cause;
        5'd14:   r = m_epc;
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  function automatic logic m_pending();
    return m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'd0);
  endfunction

  task automatic m_reset();
    m_status = 32'h0040_0000; m_cause = 32'd0; m_epc = 32'd0; m_badv = 32'd0;
    m_compare = 32'd0; m_base = 32'd0; m_cyc = 32'd0; m_timer = 1'b0;
  endtask

  // Applies one clock edge's worth of architectural effects to the model.
  task automatic m_update();
    logic exc, eret, wr, exl_old, timer_old, match;
    exc       = excepttype_i != 32'd0 && excepttype_i != 32'he;
    eret      = excepttype_i == 32'he;
    wr        = we_i && excepttype_i == 32'd0;
    exl_old   = m_status[1];
    timer_old = m_timer;
    match     = TIMER_ON && m_count() == m_compare && m_compare != 32'd0;
    if (TIMER_ON && wr && waddr_i == 5'd11) begin
      m_compare = wdata_i; m_timer = 1'b0;
    end else if (match) m_timer = 1'b1;
    if (TIMER_ON && wr && waddr_i == 5'd9) begin
      m_base = wdata_i; m_cyc = 32'd0;
    end else m_cyc = m_cyc + 32'd1;
    m_cause[15:10] = {int_i[5] | timer_old, int_i[4:0]};
    if (exc) begin
      if (!exl_old) begin
        m_epc = in_delayslot_i ? pc_i - 32'd4 : pc_i;
        m_cause[31] = in_delayslot_i;
      end
      m_status[1] = 1'b1;
      if (excepttype_i == 32'h1) m_cause[6:2] = 5'd0;
      else if (excepttype_i inside {32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc})
        m_cause[6:2] = excepttype_i[4:0];
      if (excepttype_i == 32'h4 || excepttype_i == 32'h5) m_badv = bad_addr_i;
    end else if (eret) begin
      m_status[1] = 1'b0;
    end else if (wr) begin
      case (waddr_i)
        5'd12:   m_status = 32'h0040_0000 | (wdata_i & 32'h0000_ff03);
        5'd13:   m_cause[9:8] = wdata_i[9:8];
        5'd14:   m_epc = wdata_i;
        default: ;
      endcase
    end
  endtask

  // Called 1ns after a rising edge with inputs already applied.
  task automatic step();
    #2;
    last_rdata = rdata_o;
    chk("rdata", rdata_o, m_read());
    chk("int_pending", {31'd0, int_pending_o}, {31'd0, m_pending()});
    @(posedge clk);
    m_update();
    #1;
    chk("status", status_o, m_status);
    chk("cause", cause_o, m_cause);
    chk("epc", epc_o, m_epc);
    chk("timer_int", {31'd0, timer_int_o}, {31'd0, m_timer});
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d; raddr_i = a;
    step();
    we_i = 1'b0;
  endtask

  task automatic raise(input logic [31:0] et, input logic [31:0] pc, input logic ds,
                       input logic [31:0] bad);
    excepttype_i = et; pc_i = pc; in_delayslot_i = ds; bad_addr_i = bad;
    step();
    excepttype_i = 32'd0; in_delayslot_i = 1'b0;
  endtask

  task automatic mfc0(input logic [4:0] a);
    raddr_i = a;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'd0; raddr_i = 5'd0; int_i = 6'd0;
    excepttype_i = 32'd0; pc_i = 32'd0; in_delayslot_i = 1'b0; bad_addr_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();

    chk("rst_status", status_o, 32'h0040_0000);
    chk("rst_cause", cause_o, 32'd0);
    chk("rst_epc", epc_o, 32'd0);
    chk("rst_timer", {31'd0, timer_int_o}, 32'd0);
    chk("rst_pending", {31'd0, int_pending_o}, 32'd0);
    mfc0(5'd12);
    chk("rst_mfc0_status", last_rdata, 32'h0040_0000);

    mtc0(5'd12, 32'hffff_ffff);
    chk("bypass_status", last_rdata, 32'h0040_ff03);
    chk("status_all_ones", status_o, 32'h0040_ff03);

    mtc0(5'd12, 32'd0);
    raise(32'ha, 32'hbfc0_0100, 1'b1, 32'd0);
    chk("ri_epc", epc_o, 32'hbfc0_00fc);
    chk("ri_bd", {31'd0, cause_o[31]}, 32'd1);
    chk("ri_exccode", {27'd0, cause_o[6:2]}, 32'h0a);
    chk("ri_exl", {31'd0, status_o[1]}, 32'd1);
    raise(32'ha, 32'h0000_0200, 1'b0, 32'd0);
    chk("nested_epc", epc_o, 32'hbfc0_00fc);

    raise(32'h4, 32'h0000_0300, 1'b0, 32'h8000_0003);
    mfc0(5'd8);
    chk("adel_badvaddr", last_rdata, 32'h8000_0003);
    chk("adel_exccode", {27'd0, cause_o[6:2]}, 32'h04);
    raise(32'he, 32'd0, 1'b0, 32'd0);
    chk("eret_exl", {31'd0, status_o[1]}, 32'd0);

    mtc0(5'd12, 32'h0000_1001);
    int_i = 6'b000100;
    step();
    chk("ip4_set", {31'd0, cause_o[12]}, 32'd1);
    chk("pending_on", {31'd0, int_pending_o}, 32'd1);
    mtc0(5'd12, 32'h0000_1003);
    chk("pending_exl", {31'd0, int_pending_o}, 32'd0);
    int_i = 6'd0;
    step();

`ifdef CP0_TIMER_EN
    mtc0(5'd9, 32'h0000_0100);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("timer_quiet", {31'd0, timer_int_o}, 32'd0);
    end
    step();
    chk("timer_fire", {31'd0, timer_int_o}, 32'd1);
    step();
    chk("timer_ip7", {31'd0, cause_o[15]}, 32'd1);
    mtc0(5'd11, 32'd5);
    chk("timer_clear", {31'd0, timer_int_o}, 32'd0);
`else
    mtc0(5'd9, 32'h0000_1234);
    mfc0(5'd9);
    chk("count_disabled", last_rdata, 32'd0);
    chk("timer_disabled", {31'd0, timer_int_o}, 32'd0);
`endif

    mtc0(5'd12, 32'd0);
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'hffff_ffff;
    raise(32'h8, 32'h0000_0400, 1'b0, 32'd0);
    we_i = 1'b0;
    chk("sys_drops_mtc0", status_o, 32'h0040_0002);
    chk("sys_exccode", {27'd0, cause_o[6:2]}, 32'h08);

    for (int i = 0; i < 500; i++) begin
      we_i = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0: waddr_i = 5'd8;  1: waddr_i = 5'd9;  2: waddr_i = 5'd11;
        3: waddr_i = 5'd12; 4: waddr_i = 5'd13; 5: waddr_i = 5'd14;
        default: waddr_i = 5'($urandom);
      endcase
      raddr_i = ($urandom_range(0, 1) == 0) ? waddr_i : 5'($urandom_range(7, 15));
      wdata_i = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      int_i = 6'($urandom);
      if ($urandom_range(0, 19) < 12) excepttype_i = 32'd0;
      else excepttype_i = codes[$urandom_range(0, 7)];
      pc_i = $urandom;
      in_delayslot_i = 1'($urandom_range(0, 1));
      bad_addr_i = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
